// File: rtl/load_store_unit_pkg.sv
// Shared LSU definitions: FSM state encoding, RV32I load/store funct3 codes, and
// small helpers for op legality and address alignment.
package load_store_unit_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic f3_legal(input logic load, input logic [2:0] f3);
      if (load)
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
   endfunction

   // f3[1:0] encodes access size for both loads and stores: 00 byte, 01 half, 10 word.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      case (f3[1:0])
         2'b01:   return lo[0];
         2'b10:   return lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
      case (f3[1:0])
         2'b01:   return {lo[1], 1'b0};
         2'b10:   return 2'b00;
         default: return lo;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store byte enables and lane-replicated write data,
// plus load lane extraction with sign/zero extension.
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [31:0] lane;

   always_comb begin
      be    = 4'b1111;
      wdata = store_data;
      case (funct3[1:0])
         2'b00: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{store_data[7:0]}};
         end
         2'b01: begin
            be    = 4'b0011 << {addr_lo[1], 1'b0};
            wdata = {2{store_data[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = store_data;
         end
      endcase
   end

   assign lane = rdata >> {addr_lo, 3'b000};

   always_comb begin
      load_data = lane;
      case (funct3)
         F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
         F3_H:    load_data = {{16{lane[15]}}, lane[15:0]};
         F3_BU:   load_data = {24'd0, lane[7:0]};
         F3_HU:   load_data = {16'd0, lane[15:0]};
         default: load_data = lane;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: one load/store at a time over req/gnt/rvalid; zero-wait load wb 3 cycles after accept.
// busy stalls upstream from accept until IDLE; LSU_MISALIGN_TRAP_EN traps misaligned ops instead of aligning.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int NUM_BYTES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic                 is_load,
   input  logic                 is_store,
   input  logic [2:0]           funct3,
   input  logic [XLEN-1:0]      addr,
   input  logic [XLEN-1:0]      store_data,
   input  logic [4:0]           rd,
   output logic                 busy,
   output logic                 wb_valid,
   output logic [4:0]           wb_rd,
   output logic [XLEN-1:0]      wb_data,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [XLEN-1:0]      mem_addr,
   output logic [NUM_BYTES-1:0] mem_be,
   output logic [XLEN-1:0]      mem_wdata,
   input  logic                 mem_gnt,
   input  logic                 mem_rvalid,
   input  logic [XLEN-1:0]      mem_rdata
`ifdef LSU_MISALIGN_TRAP_EN
   ,
   output logic                 misalign
`endif
);

   logic [1:0]           state;
   logic                 op_load;
   logic [2:0]           op_f3;
   logic [XLEN-1:0]      op_addr;
   logic [XLEN-1:0]      op_data;
   logic [4:0]           op_rd;
   logic [XLEN-1:0]      wb_data_q;
   logic                 accept;
   logic                 issue;
   logic [1:0]           addr_lo_eff;
   logic [NUM_BYTES-1:0] be;
   logic [XLEN-1:0]      wdata;
   logic [XLEN-1:0]      load_data;

   assign accept = (state == ST_IDLE) && in_valid && (is_load ^ is_store) && f3_legal(is_load, funct3);

`ifdef LSU_MISALIGN_TRAP_EN
   logic misalign_q;
   assign issue       = accept && !is_misaligned(funct3, addr[1:0]);
   assign addr_lo_eff = addr[1:0];
   assign misalign    = misalign_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) misalign_q <= 1'b0;
      else        misalign_q <= accept && is_misaligned(funct3, addr[1:0]);
   end
`else
   // Misaligned halfword/word accesses are silently pulled down to their natural boundary.
   assign issue       = accept;
   assign addr_lo_eff = align_lo(funct3, addr[1:0]);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         op_load   <= 1'b0;
         op_f3     <= 3'd0;
         op_addr   <= '0;
         op_data   <= '0;
         op_rd     <= 5'd0;
         wb_data_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (issue) begin
                  state   <= ST_REQ;
                  op_load <= is_load;
                  op_f3   <= funct3;
                  op_addr <= {addr[XLEN-1:2], addr_lo_eff};
                  op_data <= store_data;
                  op_rd   <= rd;
               end
            end
            ST_REQ: begin
               if (mem_gnt) state <= op_load ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  wb_data_q <= load_data;
                  state     <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   lsu_align u_align (
      .funct3     (op_f3),
      .addr_lo    (op_addr[1:0]),
      .store_data (op_data),
      .rdata      (mem_rdata),
      .be         (be),
      .wdata      (wdata),
      .load_data  (load_data)
   );

   // Memory-side outputs are zeroed outside REQ so the bus is quiet when idle.
   assign busy      = (state != ST_IDLE);
   assign mem_req   = (state == ST_REQ);
   assign mem_we    = mem_req && !op_load;
   assign mem_addr  = mem_req ? {op_addr[XLEN-1:2], 2'b00} : '0;
   assign mem_be    = mem_req ? be : '0;
   assign mem_wdata = mem_we ? wdata : '0;
   assign wb_valid  = (state == ST_DONE);
   assign wb_rd     = wb_valid ? op_rd : 5'd0;
   assign wb_data   = wb_valid ? wb_data_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; memory side is driven by hand per scenario.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, is_load, is_store;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic [4:0]  rd;
   logic        busy, wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .is_load    (is_load),
      .is_store   (is_store),
      .funct3     (funct3),
      .addr       (addr),
      .store_data (store_data),
      .rd         (rd),
      .busy       (busy),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
      ,
      .misalign   (misalign)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] r);
      in_valid = 1'b1; is_load = ld; is_store = !ld;
      funct3 = f3; addr = a; store_data = d; rd = r;
   endtask

   task automatic drop();
      in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; drop(); funct3 = 3'd0; addr = 32'd0; store_data = 32'd0; rd = 5'd0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
      #3;
      n_cmp++;
      if ({busy, wb_valid, mem_req, mem_we, mem_be, wb_rd} !== 13'd0) begin
         n_err++; $display("FAIL reset_ctrl got %b want 0", {busy, wb_valid, mem_req, mem_we, mem_be, wb_rd});
      end
      n_cmp++;
      if ((mem_addr | mem_wdata | wb_data) !== 32'd0) begin
         n_err++; $display("FAIL reset_data got %h/%h/%h want 0", mem_addr, mem_wdata, wb_data);
      end
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_sw();
      mem_gnt = 1'b1;
      issue(1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0);
      tick();
      drop();
      n_cmp++;
      if ({mem_req, mem_we, mem_be} !== 6'b111111) begin
         n_err++; $display("FAIL sw_req got req/we/be=%b want 111111", {mem_req, mem_we, mem_be});
      end
      n_cmp++;
      if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL sw_bus got addr=%h wdata=%h want 100/deadbeef", mem_addr, mem_wdata);
      end
      tick();
      n_cmp++;
      if (busy !== 1'b0 || mem_req !== 1'b0) begin
         n_err++; $display("FAIL sw_idle got busy=%b req=%b want 0/0", busy, mem_req);
      end
   endtask

   task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp, input logic [4:0] r);
      mem_gnt = 1'b1;
      issue(1'b1, f3, 32'h103, 32'd0, r);
      tick();
      drop();
      n_cmp++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
         n_err++; $display("FAIL lb_req got req=%b we=%b addr=%h want 1/0/100", mem_req, mem_we, mem_addr);
      end
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
      tick();
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      n_cmp++;
      if (wb_valid !== 1'b1 || wb_data !== exp || wb_rd !== r) begin
         n_err++; $display("FAIL lb_wb f3=%b got v=%b data=%h rd=%0d want 1/%h/%0d", f3, wb_valid, wb_data, wb_rd, exp, r);
      end
      tick();
      n_cmp++;
      if (wb_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL lb_end got v=%b busy=%b want 0/0", wb_valid, busy);
      end
   endtask

   task automatic test_sh_stall();
      mem_gnt = 1'b0;
      issue(1'b0, 3'b001, 32'h102, 32'h1234ABCD, 5'd0);
      tick();
      drop();
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b1100 || mem_wdata !== 32'hABCDABCD) begin
            n_err++; $display("FAIL sh_stall%0d got req=%b addr=%h be=%b wdata=%h want 1/100/1100/abcdabcd",
                              i, mem_req, mem_addr, mem_be, mem_wdata);
         end
         tick();
      end
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || mem_req !== 1'b0) begin
         n_err++; $display("FAIL sh_idle got busy=%b req=%b want 0/0", busy, mem_req);
      end
   endtask

   task automatic test_lw_slow();
      int pulses = 0;
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
      tick();
      mem_rvalid = 1'b0;
      n_cmp++;
      if (wb_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL idle_rvalid got v=%b busy=%b want 0/0", wb_valid, busy);
      end
      mem_gnt = 1'b1;
      issue(1'b1, 3'b010, 32'h10, 32'd0, 5'd7);
      tick();
      drop();
      tick();
      mem_gnt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (busy !== 1'b1 || wb_valid !== 1'b0) begin
            n_err++; $display("FAIL lw_wait%0d got busy=%b v=%b want 1/0", i, busy, wb_valid);
         end
         tick();
      end
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
      for (int i = 0; i < 3; i++) begin
         tick();
         mem_rvalid = 1'b0;
         if (wb_valid === 1'b1) begin
            pulses++;
            n_cmp++;
            if (wb_data !== 32'hCAFEF00D || wb_rd !== 5'd7 || i != 0) begin
               n_err++; $display("FAIL lw_wb cyc%0d got data=%h rd=%0d want cafef00d/7 at cyc0", i, wb_data, wb_rd);
            end
         end
      end
      n_cmp++;
      if (pulses != 1 || busy !== 1'b0) begin
         n_err++; $display("FAIL lw_pulses got %0d busy=%b want 1/0", pulses, busy);
      end
   endtask

   task automatic test_reset_in_wait();
      mem_gnt = 1'b1;
      issue(1'b1, 3'b010, 32'h20, 32'd0, 5'd3);
      tick();
      drop();
      tick();
      mem_gnt = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL rst_pre got busy=%b want 1", busy);
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ({busy, wb_valid, mem_req, mem_we, mem_be, wb_rd} !== 13'd0 || (mem_addr | mem_wdata | wb_data) !== 32'd0) begin
         n_err++; $display("FAIL rst_async got ctrl=%b addr=%h want 0", {busy, wb_valid, mem_req, mem_we, mem_be, wb_rd}, mem_addr);
      end
      tick();
      reset = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
      tick();
      mem_rvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (wb_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rst_late%0d got v=%b busy=%b want 0/0", i, wb_valid, busy);
         end
         tick();
      end
      mem_gnt = 1'b1;
      issue(1'b0, 3'b000, 32'h201, 32'h0000_00A5, 5'd0);
      tick();
      drop();
      n_cmp++;
      if (mem_req !== 1'b1 || mem_be !== 4'b0010 || mem_wdata !== 32'hA5A5A5A5 || mem_addr !== 32'h200) begin
         n_err++; $display("FAIL rst_next got req=%b be=%b wdata=%h addr=%h want 1/0010/a5a5a5a5/200",
                           mem_req, mem_be, mem_wdata, mem_addr);
      end
      tick();
      mem_gnt = 1'b0;
   endtask

   task automatic test_illegal();
      is_load = 1'b1; is_store = 1'b1; in_valid = 1'b1; funct3 = 3'b010; addr = 32'h40;
      tick();
      n_cmp++;
      if (busy !== 1'b0 || mem_req !== 1'b0) begin
         n_err++; $display("FAIL ill_both got busy=%b req=%b want 0/0", busy, mem_req);
      end
      issue(1'b1, 3'b011, 32'h40, 32'd0, 5'd1);
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL ill_ld011 got busy=%b want 0", busy);
      end
      issue(1'b0, 3'b011, 32'h40, 32'd0, 5'd0);
      tick();
      drop();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL ill_st011 got busy=%b want 0", busy);
      end
   endtask

   task automatic test_misalign();
      mem_gnt = 1'b1;
      issue(1'b1, 3'b010, 32'h102, 32'd0, 5'd9);
      tick();
      drop();
`ifdef LSU_MISALIGN_TRAP_EN
      n_cmp++;
      if (misalign !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL mis_trap got mis=%b req=%b busy=%b want 1/0/0", misalign, mem_req, busy);
      end
      tick();
      n_cmp++;
      if (misalign !== 1'b0 || wb_valid !== 1'b0) begin
         n_err++; $display("FAIL mis_pulse got mis=%b v=%b want 0/0", misalign, wb_valid);
      end
`else
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b1111) begin
         n_err++; $display("FAIL mis_align got req=%b addr=%h be=%b want 1/100/1111", mem_req, mem_addr, mem_be);
      end
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
      tick();
      mem_rvalid = 1'b0;
      n_cmp++;
      if (wb_valid !== 1'b1 || wb_data !== 32'h0BADF00D || wb_rd !== 5'd9) begin
         n_err++; $display("FAIL mis_wb got v=%b data=%h rd=%0d want 1/0badf00d/9", wb_valid, wb_data, wb_rd);
      end
      tick();
`endif
      mem_gnt = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sw();
      test_load_byte(3'b000, 32'hFFFF_FF80, 5'd5);
      test_load_byte(3'b100, 32'h0000_0080, 5'd0);
      test_sh_stall();
      test_lw_slow();
      test_reset_in_wait();
      test_illegal();
      test_misalign();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
